// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction-fetch unit: FSM states, width defaults,
// HALT encoding and the branch-target table.
package instr_fetch_pkg;

    localparam int PC_W_DEF  = 10;
    localparam int LUT_W_DEF = 5;
    localparam int LUT_DEPTH = 1 << LUT_W_DEF;

    localparam logic [2:0] HALT_OP   = 3'b110;
    localparam logic [2:0] HALT_FUNC = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    // Absolute branch targets; entries left at zero are unpopulated.
    localparam logic [PC_W_DEF-1:0] BRANCH_TABLE [LUT_DEPTH] = '{
        10'h008, 10'h030, 10'h100, 10'h040, 10'h3F0, 10'h055, 10'h200, 10'h020,
        10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000,
        10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000,
        10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000
    };

    function automatic logic is_halt(input logic [2:0] op, input logic [2:0] func);
        return (op == HALT_OP) && (func == HALT_FUNC);
    endfunction

endpackage

// File: rtl/instr_fetch_branch_lut.sv
// Combinational branch-target lookup: table index to absolute PC target.
module branch_lut
    import instr_fetch_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int LUT_W = LUT_W_DEF
) (
    input  logic [LUT_W-1:0] lut_idx_i,
    output logic [PC_W-1:0]  target_o
);

    // Indices beyond the table fall through to the zero default.
    always_comb begin
        target_o = '0;
        for (int i = 0; i < LUT_DEPTH; i++) begin
            if (32'(lut_idx_i) == 32'(i)) begin
                target_o = PC_W'(BRANCH_TABLE[i]);
            end
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Program-counter sequencer: IDLE -> RUN -> HALTED with conditional absolute
// branches through branch_lut and modulo-2^PC_W increment.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int LUT_W = LUT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PC_W-1:0]  start_addr,
    input  logic             branch,
    input  logic [LUT_W-1:0] lut_idx,
    input  logic             overflow,
    input  logic             halt,
    output logic [PC_W-1:0]  pc,
    output logic             running,
    output logic             done
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] lutTarget;

    branch_lut #(
        .PC_W  (PC_W),
        .LUT_W (LUT_W)
    ) u_branch_lut (
        .lut_idx_i (lut_idx),
        .target_o  (lutTarget)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // halt outranks branch; overflow only matters for a branch in RUN.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    pc_d    = start_addr;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (halt) begin
                    state_d = HALTED;
                end else if (branch && overflow) begin
                    pc_d = lutTarget;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            HALTED: begin
                if (start) begin
                    pc_d    = start_addr;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = '0;
            end
        endcase
    end

    assign pc      = pc_q;
    assign running = (state_q == RUN);
    assign done    = (state_q == HALTED);

endmodule
